// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// datapath mux selects and trap causes.
package riscv_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_TRAP      = 3'd5,
      ST_HALT      = 3'd6
   } state_e;

   localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
   localparam logic [1:0] PC_SEL_ALU   = 2'b01;
   localparam logic [1:0] PC_SEL_TRAP  = 2'b10;

   localparam logic [1:0] ALU_A_RS1  = 2'b00;
   localparam logic [1:0] ALU_A_PC   = 2'b01;
   localparam logic [1:0] ALU_A_ZERO = 2'b10;

   localparam logic [1:0] ALU_B_RS2 = 2'b00;
   localparam logic [1:0] ALU_B_IMM = 2'b01;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // Opcodes that proceed to EXECUTE; SYSTEM is handled separately (halt).
   function automatic logic is_exec_opcode(input logic [6:0] opc);
      logic ok;
      case (opc)
         OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
         OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC: ok = 1'b1;
         default:                                ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags when the wait limit is hit.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic waiting,
   output logic expired
);

   localparam logic [TO_W-1:0] LIMIT_M1  = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : {TO_W{1'b0}};
   localparam logic [TO_W-1:0] COUNT_MAX = {TO_W{1'b1}};

   logic [TO_W-1:0] count_r;
   logic            expired_s;

   // Wait counter; saturates so a disabled timeout never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {TO_W{1'b0}};
      end else if (clear) begin
         count_r <= {TO_W{1'b0}};
      end else if (waiting && (count_r != COUNT_MAX)) begin
         count_r <= count_r + TO_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Expire on the wait cycle whose increment would reach the limit.
   always_comb begin
      expired_s = 1'b0;
      if ((MEM_TIMEOUT > 0) && waiting && (count_r == LIMIT_M1)) begin
         expired_s = 1'b1;
      end else begin
         expired_s = 1'b0;
      end
   end

   assign expired = expired_s;

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback,
// raises traps on illegal opcodes and memory timeouts, and counts cycles/retires.
module mc_control_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             take_branch,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic             ir_write,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       wb_sel,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic             halted,
   output logic             retire,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instret_count
);

   state_e           state_r, next_s;
   logic [1:0]       cause_r;
   logic             set_cause_s;
   logic [1:0]       new_cause_s;
   logic [CNT_W-1:0] cycle_r, instret_r;
   logic             in_wait_s, expired_s;

   assign in_wait_s = (state_r == ST_FETCH) || (state_r == ST_MEM);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!in_wait_s || mem_ready),
      .waiting (in_wait_s && !mem_ready),
      .expired (expired_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      next_s      = state_r;
      set_cause_s = 1'b0;
      new_cause_s = CAUSE_NONE;
      pc_write    = 1'b0;
      pc_sel      = PC_SEL_PLUS4;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      alu_src_a   = ALU_A_RS1;
      alu_src_b   = ALU_B_RS2;
      wb_sel      = WB_ALU;
      trap        = 1'b0;
      halted      = 1'b0;
      retire      = 1'b0;
      case (state_r)
         ST_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               next_s   = ST_DECODE;
            end else if (expired_s) begin
               next_s      = ST_TRAP;
               set_cause_s = 1'b1;
               new_cause_s = CAUSE_TIMEOUT;
            end else begin
               next_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (opcode == OPC_SYSTEM) begin
               next_s = ST_HALT;
            end else if (is_exec_opcode(opcode)) begin
               next_s = ST_EXECUTE;
            end else begin
               next_s      = ST_TRAP;
               set_cause_s = 1'b1;
               new_cause_s = CAUSE_ILLEGAL;
            end
         end
         ST_EXECUTE: begin
            case (opcode)
               OPC_OP:                                   begin alu_src_a = ALU_A_RS1;  alu_src_b = ALU_B_RS2; end
               OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: begin alu_src_a = ALU_A_RS1;  alu_src_b = ALU_B_IMM; end
               OPC_LUI:                                  begin alu_src_a = ALU_A_ZERO; alu_src_b = ALU_B_IMM; end
               OPC_AUIPC, OPC_JAL, OPC_BRANCH:           begin alu_src_a = ALU_A_PC;   alu_src_b = ALU_B_IMM; end
               default:                                  begin alu_src_a = ALU_A_RS1;  alu_src_b = ALU_B_RS2; end
            endcase
            if (opcode == OPC_BRANCH) begin
               pc_write = 1'b1;
               pc_sel   = take_branch ? PC_SEL_ALU : PC_SEL_PLUS4;
               retire   = 1'b1;
               next_s   = ST_FETCH;
            end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
               next_s = ST_MEM;
            end else begin
               next_s = ST_WRITEBACK;
            end
         end
         ST_MEM: begin
            if (opcode == OPC_STORE) begin
               mem_write = 1'b1;
            end else begin
               mem_read = 1'b1;
            end
            if (mem_ready) begin
               if (opcode == OPC_STORE) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  next_s   = ST_FETCH;
               end else begin
                  next_s = ST_WRITEBACK;
               end
            end else if (expired_s) begin
               next_s      = ST_TRAP;
               set_cause_s = 1'b1;
               new_cause_s = CAUSE_TIMEOUT;
            end else begin
               next_s = ST_MEM;
            end
         end
         ST_WRITEBACK: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
            next_s    = ST_FETCH;
            if (opcode == OPC_LOAD) begin
               wb_sel = WB_MEM;
            end else if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
               wb_sel = WB_PC4;
               pc_sel = PC_SEL_ALU;
            end else begin
               wb_sel = WB_ALU;
            end
         end
         ST_TRAP: begin
            trap     = 1'b1;
            pc_write = 1'b1;
            pc_sel   = PC_SEL_TRAP;
            next_s   = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
            next_s = ST_HALT;
         end
         default: begin
            next_s = ST_FETCH;
         end
      endcase
   end

   // Trap cause latch and performance counters; HALT freezes the cycle count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cause_r   <= CAUSE_NONE;
         cycle_r   <= {CNT_W{1'b0}};
         instret_r <= {CNT_W{1'b0}};
      end else begin
         cause_r   <= set_cause_s ? new_cause_s : cause_r;
         cycle_r   <= (state_r != ST_HALT) ? cycle_r + CNT_W'(1) : cycle_r;
         instret_r <= retire ? instret_r + CNT_W'(1) : instret_r;
      end
   end

   assign trap_cause    = cause_r;
   assign cycle_count   = cycle_r;
   assign instret_count = instret_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed-vector bench for mc_control_unit; control outputs are checked as one
// packed word {pc_write,pc_sel,ir_write,reg_write,mem_read,mem_write,a,b,wb,trap,halted,retire}.
module tb_mc_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic        take_branch;
   logic        mem_ready;
   logic        pc_write, ir_write, reg_write, mem_read, mem_write, trap, halted, retire;
   logic [1:0]  pc_sel, alu_src_a, alu_src_b, wb_sel, trap_cause;
   logic [31:0] cycle_count, instret_count;
   logic [15:0] ctl;
   logic [15:0] exp_ctl;

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [15:0] C_FETCH_RDY  = 16'b0_00_1_0_1_0_00_00_00_0_0_0;
   localparam logic [15:0] C_FETCH_WAIT = 16'b0_00_0_0_1_0_00_00_00_0_0_0;
   localparam logic [15:0] C_IDLE       = 16'b0_00_0_0_0_0_00_00_00_0_0_0;
   localparam logic [15:0] C_EX_IMM     = 16'b0_00_0_0_0_0_00_01_00_0_0_0;
   localparam logic [15:0] C_EX_PCIMM   = 16'b0_00_0_0_0_0_01_01_00_0_0_0;
   localparam logic [15:0] C_WB_ALU     = 16'b1_00_0_1_0_0_00_00_00_0_0_1;
   localparam logic [15:0] C_WB_LOAD    = 16'b1_00_0_1_0_0_00_00_01_0_0_1;
   localparam logic [15:0] C_WB_JAL     = 16'b1_01_0_1_0_0_00_00_10_0_0_1;
   localparam logic [15:0] C_MEM_RD     = 16'b0_00_0_0_1_0_00_00_00_0_0_0;
   localparam logic [15:0] C_MEM_WR     = 16'b0_00_0_0_0_1_00_00_00_0_0_0;
   localparam logic [15:0] C_MEM_WR_OK  = 16'b1_00_0_0_0_1_00_00_00_0_0_1;
   localparam logic [15:0] C_BR_TAKEN   = 16'b1_01_0_0_0_0_01_01_00_0_0_1;
   localparam logic [15:0] C_BR_NOT     = 16'b1_00_0_0_0_0_01_01_00_0_0_1;
   localparam logic [15:0] C_TRAP       = 16'b1_10_0_0_0_0_00_00_00_1_0_0;
   localparam logic [15:0] C_HALT       = 16'b0_00_0_0_0_0_00_00_00_0_1_0;

   assign ctl = {pc_write, pc_sel, ir_write, reg_write, mem_read, mem_write,
                 alu_src_a, alu_src_b, wb_sel, trap, halted, retire};

   always #5 clk = ~clk;

   mc_control_unit #(.CNT_W(32), .MEM_TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .take_branch(take_branch), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_sel(pc_sel), .ir_write(ir_write), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .halted(halted), .retire(retire),
      .cycle_count(cycle_count), .instret_count(instret_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      mem_ready = 1'b0; opcode = 7'b0010011; take_branch = 1'b0;
      do_reset();
      #1;
      vectors++; if (ctl !== C_FETCH_WAIT) begin miscompares++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_FETCH_WAIT); end
      vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL reset_cycle got=%0d exp=0", cycle_count); end
      vectors++; if (instret_count !== 32'd0) begin miscompares++; $display("FAIL reset_instret got=%0d exp=0", instret_count); end
      vectors++; if (trap_cause !== 2'b00) begin miscompares++; $display("FAIL reset_cause got=%b exp=00", trap_cause); end
   endtask

   task automatic test_addi();
      do_reset(); opcode = 7'b0010011; mem_ready = 1'b1; #1;
      vectors++; if (ctl !== C_FETCH_RDY) begin miscompares++; $display("FAIL addi_fetch got=%b exp=%b", ctl, C_FETCH_RDY); end
      tick();
      vectors++; if (ctl !== C_IDLE) begin miscompares++; $display("FAIL addi_decode got=%b exp=%b", ctl, C_IDLE); end
      tick();
      vectors++; if (ctl !== C_EX_IMM) begin miscompares++; $display("FAIL addi_exec got=%b exp=%b", ctl, C_EX_IMM); end
      tick();
      vectors++; if (ctl !== C_WB_ALU) begin miscompares++; $display("FAIL addi_wb got=%b exp=%b", ctl, C_WB_ALU); end
      tick();
      vectors++; if (ctl !== C_FETCH_RDY) begin miscompares++; $display("FAIL addi_refetch got=%b exp=%b", ctl, C_FETCH_RDY); end
      vectors++; if (instret_count !== 32'd1) begin miscompares++; $display("FAIL addi_instret got=%0d exp=1", instret_count); end
      vectors++; if (cycle_count !== 32'd4) begin miscompares++; $display("FAIL addi_cycles got=%0d exp=4", cycle_count); end
   endtask

   task automatic test_load();
      do_reset(); opcode = 7'b0000011; mem_ready = 1'b1;
      tick(); tick();
      vectors++; if (ctl !== C_EX_IMM) begin miscompares++; $display("FAIL load_exec got=%b exp=%b", ctl, C_EX_IMM); end
      tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if (ctl !== C_MEM_RD) begin miscompares++; $display("FAIL load_mem_wait%0d got=%b exp=%b", i, ctl, C_MEM_RD); end
         tick();
      end
      mem_ready = 1'b1; #1;
      vectors++; if (ctl !== C_MEM_RD) begin miscompares++; $display("FAIL load_mem_done got=%b exp=%b", ctl, C_MEM_RD); end
      tick();
      vectors++; if (ctl !== C_WB_LOAD) begin miscompares++; $display("FAIL load_wb got=%b exp=%b", ctl, C_WB_LOAD); end
      tick();
      vectors++; if (cycle_count !== 32'd8) begin miscompares++; $display("FAIL load_cycles got=%0d exp=8", cycle_count); end
      vectors++; if (instret_count !== 32'd1) begin miscompares++; $display("FAIL load_instret got=%0d exp=1", instret_count); end
   endtask

   task automatic test_branch();
      do_reset(); opcode = 7'b1100011; mem_ready = 1'b1; take_branch = 1'b1;
      tick(); tick(); #1;
      vectors++; if (ctl !== C_BR_TAKEN) begin miscompares++; $display("FAIL br_taken got=%b exp=%b", ctl, C_BR_TAKEN); end
      tick();
      take_branch = 1'b0;
      tick(); tick(); #1;
      vectors++; if (ctl !== C_BR_NOT) begin miscompares++; $display("FAIL br_not_taken got=%b exp=%b", ctl, C_BR_NOT); end
      tick();
      vectors++; if (instret_count !== 32'd2) begin miscompares++; $display("FAIL br_instret got=%0d exp=2", instret_count); end
      vectors++; if (cycle_count !== 32'd6) begin miscompares++; $display("FAIL br_cycles got=%0d exp=6", cycle_count); end
   endtask

   task automatic test_jal();
      do_reset(); opcode = 7'b1101111; mem_ready = 1'b1;
      tick(); tick();
      vectors++; if (ctl !== C_EX_PCIMM) begin miscompares++; $display("FAIL jal_exec got=%b exp=%b", ctl, C_EX_PCIMM); end
      tick();
      vectors++; if (ctl !== C_WB_JAL) begin miscompares++; $display("FAIL jal_wb got=%b exp=%b", ctl, C_WB_JAL); end
   endtask

   task automatic test_illegal();
      do_reset(); opcode = 7'b1111111; mem_ready = 1'b1;
      tick();
      vectors++; if (ctl !== C_IDLE) begin miscompares++; $display("FAIL ill_decode got=%b exp=%b", ctl, C_IDLE); end
      tick();
      vectors++; if (ctl !== C_TRAP) begin miscompares++; $display("FAIL ill_trap got=%b exp=%b", ctl, C_TRAP); end
      vectors++; if (trap_cause !== 2'b01) begin miscompares++; $display("FAIL ill_cause got=%b exp=01", trap_cause); end
      tick();
      vectors++; if (ctl !== C_FETCH_RDY) begin miscompares++; $display("FAIL ill_refetch got=%b exp=%b", ctl, C_FETCH_RDY); end
      vectors++; if (trap_cause !== 2'b01) begin miscompares++; $display("FAIL ill_cause_held got=%b exp=01", trap_cause); end
      vectors++; if (instret_count !== 32'd0) begin miscompares++; $display("FAIL ill_instret got=%0d exp=0", instret_count); end
   endtask

   task automatic test_timeout();
      // STORE that completes exactly on the limit cycle: completion wins.
      do_reset(); opcode = 7'b0100011; mem_ready = 1'b1;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if (ctl !== C_MEM_WR) begin miscompares++; $display("FAIL st_edge_wait%0d got=%b exp=%b", i, ctl, C_MEM_WR); end
         tick();
      end
      mem_ready = 1'b1; #1;
      vectors++; if (ctl !== C_MEM_WR_OK) begin miscompares++; $display("FAIL st_edge_done got=%b exp=%b", ctl, C_MEM_WR_OK); end
      tick();
      vectors++; if (trap_cause !== 2'b00) begin miscompares++; $display("FAIL st_edge_cause got=%b exp=00", trap_cause); end
      vectors++; if (instret_count !== 32'd1) begin miscompares++; $display("FAIL st_edge_instret got=%0d exp=1", instret_count); end
      // STORE that never completes: trap after four wait cycles.
      do_reset(); mem_ready = 1'b1;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++; if (ctl !== C_MEM_WR) begin miscompares++; $display("FAIL st_to_wait%0d got=%b exp=%b", i, ctl, C_MEM_WR); end
         tick();
      end
      vectors++; if (ctl !== C_TRAP) begin miscompares++; $display("FAIL st_to_trap got=%b exp=%b", ctl, C_TRAP); end
      vectors++; if (trap_cause !== 2'b10) begin miscompares++; $display("FAIL st_to_cause got=%b exp=10", trap_cause); end
      vectors++; if (instret_count !== 32'd0) begin miscompares++; $display("FAIL st_to_instret got=%0d exp=0", instret_count); end
      // Fetch that never completes also traps.
      do_reset(); mem_ready = 1'b0;
      tick(); tick(); tick();
      vectors++; if (ctl !== C_FETCH_WAIT) begin miscompares++; $display("FAIL fetch_to_last got=%b exp=%b", ctl, C_FETCH_WAIT); end
      tick();
      vectors++; if (ctl !== C_TRAP) begin miscompares++; $display("FAIL fetch_to_trap got=%b exp=%b", ctl, C_TRAP); end
   endtask

   task automatic test_halt();
      do_reset(); opcode = 7'b1110011; mem_ready = 1'b1;
      vectors++; if (trap_cause !== 2'b00) begin miscompares++; $display("FAIL halt_cause_clr got=%b exp=00", trap_cause); end
      tick(); tick();
      vectors++; if (ctl !== C_HALT) begin miscompares++; $display("FAIL halt_ctl got=%b exp=%b", ctl, C_HALT); end
      vectors++; if (cycle_count !== 32'd2) begin miscompares++; $display("FAIL halt_cycles got=%0d exp=2", cycle_count); end
      tick(); tick(); tick();
      vectors++; if (ctl !== C_HALT) begin miscompares++; $display("FAIL halt_stay got=%b exp=%b", ctl, C_HALT); end
      vectors++; if (cycle_count !== 32'd2) begin miscompares++; $display("FAIL halt_frozen got=%0d exp=2", cycle_count); end
      mem_ready = 1'b0;
      do_reset(); #1;
      vectors++; if (ctl !== C_FETCH_WAIT) begin miscompares++; $display("FAIL halt_rst_ctl got=%b exp=%b", ctl, C_FETCH_WAIT); end
      vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL halt_rst_cycles got=%0d exp=0", cycle_count); end
      tick(); tick();
      vectors++; if (cycle_count !== 32'd2) begin miscompares++; $display("FAIL fwait_cycles got=%0d exp=2", cycle_count); end
      do_reset(); #1;
      vectors++; if (ctl !== C_FETCH_WAIT) begin miscompares++; $display("FAIL fwait_rst_ctl got=%b exp=%b", ctl, C_FETCH_WAIT); end
      vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL fwait_rst_cycles got=%0d exp=0", cycle_count); end
      tick();
      vectors++; if (cycle_count !== 32'd1) begin miscompares++; $display("FAIL fwait_resume got=%0d exp=1", cycle_count); end
   endtask

   initial begin
      rst = 1'b1; opcode = 7'b0000000; take_branch = 1'b0; mem_ready = 1'b0;
      test_reset();
      test_addi();
      test_load();
      test_branch();
      test_jal();
      test_illegal();
      test_timeout();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Parametrised next-generation multicycle RV32I control FSM. Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a variable-latency memory with a req/ready handshake. Detects illegal opcodes and memory timeouts and raises a trap. Halts on SYSTEM and keeps cycle and retired-instruction counters. Sits between the instruction register/decoder and the datapath muxes, PC register, register file and memory port.

Parameters:
CNT_W, 32, width of cycle_count and instret_count; both wrap modulo 2^CNT_W.
MEM_TIMEOUT, 16, max wait cycles for mem_ready; 0 disables timeout.
TO_W, 8, width of the timeout counter; MEM_TIMEOUT must be less than 2^TO_W.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
opcode  in  7  instr[6:0] from the IR.
take_branch  in  1  branch comparator result.
mem_ready  in  1  memory has completed the current read/write this cycle.
pc_write  out  1  PC load enable.
pc_sel  out  2  00 PC+4, 01 ALU target, 10 trap vector.
ir_write  out  1  IR load enable.
reg_write  out  1  register-file write enable.
mem_read  out  1  memory read request, held until mem_ready.
mem_write  out  1  memory write request, held until mem_ready.
alu_src_a  out  2  00 rs1, 01 PC, 10 zero.
alu_src_b  out  2  00 rs2, 01 imm.
wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4.
trap  out  1  one-cycle pulse in TRAP state.
trap_cause  out  2  01 illegal opcode, 10 memory timeout; held until next trap or reset.
halted  out  1  high in HALT.
retire  out  1  one-cycle pulse when an instruction completes.
cycle_count  out  CNT_W  cycle counter.
instret_count  out  CNT_W  retired-instruction counter.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP, HALT.
- Reset (sync, rst=1 at posedge): state FETCH; counters, trap_cause and the timeout counter 0. rst has priority over everything, including mid-handshake; the aborted request is simply dropped.
- Outputs are combinational from state/opcode/take_branch/mem_ready. Each output not listed for a state is 0.
- FETCH:
  - mem_read=1.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready=1: ir_write=1, go to DECODE.
- DECODE (1 cycle):
  - LOAD, STORE, BRANCH, JAL, JALR, OP_IMM, OP, LUI, AUIPC go to EXECUTE.
  - SYSTEM goes to HALT.
  - Any other opcode goes to TRAP with cause 01.
- EXECUTE (1 cycle), ALU source selects:
  - OP: a=00, b=00.
  - OP_IMM, LOAD, STORE, JALR: a=00, b=01.
  - LUI: a=10, b=01.
  - AUIPC, JAL, BRANCH: a=01, b=01.
- EXECUTE exits:
  - BRANCH: pc_write=1, pc_sel = take_branch ? 01 : 00, retire=1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WRITEBACK.
- MEM:
  - mem_read=1 (LOAD) or mem_write=1 (STORE), held every cycle until mem_ready=1.
  - LOAD complete: go to WRITEBACK.
  - STORE complete: pc_write=1, pc_sel=00, retire=1, go to FETCH.
- WRITEBACK (1 cycle):
  - reg_write=1; pc_write=1; retire=1; go to FETCH.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_sel: 01 for JAL/JALR, 00 otherwise.
- Timeout (FETCH and MEM only):
  - Counter clears on entry to FETCH/MEM and on completion; increments each cycle mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: drop the request, go to TRAP, cause 10.
  - mem_ready=1 in the same cycle the counter reaches the limit: completion wins.
- TRAP (1 cycle): trap=1, pc_write=1, pc_sel=10, no retire, go to FETCH.
- HALT: all enables 0, halted=1; exits only via rst.
- Counters:
  - cycle_count increments every cycle not in HALT and not in reset.
  - instret_count increments on retire.
  - Both wrap to 0 at 2^CNT_W.
- Invariant: exactly one pc_write per instruction or trap. pc_write and ir_write are never both 1 in one cycle.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode localparams;
  - the state enum (logic [2:0]);
  - pc_sel, alu_src_a, alu_src_b and wb_sel encodings;
  - trap_cause encodings.
- Sub-module mem_wait_timer (params MEM_TIMEOUT, TO_W; ports clk, rst, clear, waiting, expired) holds the timeout counter.
- The rest stays in one module.

Test Plan:
- ADDI (opcode 0010011), mem_ready always 1 -> FETCH, DECODE, EXECUTE, WRITEBACK in 4 cycles; alu_src_b=01; reg_write=1 and pc_sel=00 in WRITEBACK; instret_count 0→1.
- LOAD with mem_ready delayed 3 cycles in MEM -> mem_read held high for 4 cycles; WRITEBACK wb_sel=01; total 8 cycles.
- BRANCH twice, take_branch=1 then 0 -> pc_sel=01 then 00 in EXECUTE; no reg_write; 3 cycles each; instret_count +2.
- Opcode 7'b1111111 -> TRAP pulse on cycle 3; pc_sel=10; trap_cause=01; instret_count unchanged.
- MEM_TIMEOUT=4, STORE with mem_ready never high -> TRAP after 4 MEM wait cycles; mem_write drops; trap_cause=10.
- SYSTEM (1110011) -> halted=1 and cycle_count frozen; rst=1 mid-HALT and again mid-FETCH-wait -> FETCH, counters 0, mem_read reasserted next cycle.
